// File: rtl/m68k_uart.sv
// m68k_uart: byte-wide 8N1 UART on the 68k bus, clocked by clk16.
// Register side effects fire once, on the IDLE->ACK edge of the bus FSM.
// Optional feature: define M68K_UART_IRQ_EN to add the CTRL register (addr 4)
// and the active-low irq_n output.
module m68k_uart #(
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned DIV_RESET = 138
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       as_n,
    input  logic       lds_n,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic       dtack_n,
    output logic       txd,
    input  logic       rxd
`ifdef M68K_UART_IRQ_EN
    ,
    output logic       irq_n
`endif
);

    localparam int unsigned   AW       = $clog2(RX_DEPTH);
    localparam logic [AW:0]   FULL_CNT = RX_DEPTH[AW:0];
    localparam logic [15:0]   DIV_INIT = DIV_RESET[15:0];

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    bus_state_t  bus_state;
    tx_state_t   tx_state;
    rx_state_t   rx_state;

    logic        bus_start, bus_fire, rd_fire, wr_fire;
    logic [7:0]  rd_data;
    logic [15:0] div_reg, eff_div;

    logic [7:0]  tx_hold, tx_shift;
    logic        tx_full, tx_wr, tx_bit_end;
    logic [15:0] tx_div, tx_cnt;
    logic [2:0]  tx_bit;

    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_div, rx_cnt, rx_half_end;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_wait_high, rx_push, rx_ferr_set;

    logic [7:0]  fifo_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] rx_count;
    logic        rx_nonempty, fifo_full, pop, fifo_wr;
    logic        rx_overrun, frame_err;

`ifdef M68K_UART_IRQ_EN
    logic        rx_ie, tx_ie;
`endif

    // Byte lane qualifies the side effect; an upper-lane-only cycle is still acknowledged.
    assign bus_start   = (bus_state == BUS_IDLE) && !cs_n && !as_n;
    assign bus_fire    = bus_start && !lds_n;
    assign rd_fire     = bus_fire && rw;
    assign wr_fire     = bus_fire && !rw;

    assign eff_div     = (div_reg < 16'd4) ? 16'd4 : div_reg;
    assign rx_nonempty = (rx_count != '0);
    assign fifo_full   = (rx_count == FULL_CNT);
    assign pop         = rd_fire && (addr == 3'd0) && rx_nonempty;
    assign fifo_wr     = rx_push && (!fifo_full || pop);
    assign tx_wr       = wr_fire && (addr == 3'd0) && !tx_full;
    assign tx_bit_end  = (tx_cnt == tx_div - 16'd1);
    assign rx_half_end = {1'b0, rx_div[15:1]} - 16'd1;

    // Register read mux
    always_comb begin
        rd_data = '0;
        case (addr)
            3'd0: if (rx_nonempty) rd_data = fifo_mem[rd_ptr];
            3'd1: rd_data = {4'b0000, frame_err, rx_overrun, !tx_full, rx_nonempty};
            3'd2: rd_data = div_reg[7:0];
            3'd3: rd_data = div_reg[15:8];
`ifdef M68K_UART_IRQ_EN
            3'd4: rd_data = {6'b000000, tx_ie, rx_ie};
`endif
            default: rd_data = '0;
        endcase
    end

    // Bus handshake FSM with registered dtack_n, dout and dout_oe
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            bus_state <= BUS_IDLE;
            dtack_n   <= 1'b1;
            dout      <= '0;
            dout_oe   <= 1'b0;
        end else begin
            case (bus_state)
                BUS_IDLE: if (bus_start) begin
                    bus_state <= BUS_ACK;
                    dtack_n   <= 1'b0;
                    dout_oe   <= rw;
                    dout      <= (!lds_n && rw) ? rd_data : '0;
                end
                BUS_ACK: if (as_n) begin
                    bus_state <= BUS_IDLE;
                    dtack_n   <= 1'b1;
                    dout_oe   <= 1'b0;
                end
                default: bus_state <= BUS_IDLE;
            endcase
        end
    end

    // Divisor and control registers
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_INIT;
`ifdef M68K_UART_IRQ_EN
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
`endif
        end else if (wr_fire) begin
            case (addr)
                3'd2: div_reg[7:0]  <= din;
                3'd3: div_reg[15:8] <= din;
`ifdef M68K_UART_IRQ_EN
                3'd4: begin
                    rx_ie <= din[0];
                    tx_ie <= din[1];
                end
`endif
                default: ;
            endcase
        end
    end

    // Transmitter: holding register plus shifter; STOP chains straight into START
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            txd      <= 1'b1;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
            tx_shift <= '0;
            tx_div   <= DIV_INIT;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    txd    <= 1'b1;
                    if (tx_full) begin
                        tx_shift <= tx_hold;
                        tx_full  <= 1'b0;
                        tx_div   <= eff_div;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: if (tx_bit_end) begin
                    tx_cnt   <= '0;
                    txd      <= tx_shift[0];
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_bit == 3'd7) begin
                        txd      <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        txd      <= tx_shift[1];
                    end
                end
                TX_STOP: if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_full) begin
                        tx_shift <= tx_hold;
                        tx_full  <= 1'b0;
                        tx_div   <= eff_div;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
            // Load and write are exclusive: a write only lands while the holding register is empty
            if (tx_wr) begin
                tx_hold <= din;
                tx_full <= 1'b1;
            end
        end
    end

    // rxd synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver: mid-bit sampling, false-start rejection, stop-bit check
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_div       <= DIV_INIT;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
            rx_push      <= 1'b0;
            rx_ferr_set  <= 1'b0;
        end else begin
            rx_push     <= 1'b0;
            rx_ferr_set <= 1'b0;
            rx_cnt      <= rx_cnt + 16'd1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) begin
                        rx_div   <= eff_div;
                        rx_state <= RX_START;
                    end
                end
                RX_START: if (rx_cnt == rx_half_end) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt == rx_div - 16'd1) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    if (rx_wait_high) begin
                        if (rx_s2) begin
                            rx_wait_high <= 1'b0;
                            rx_state     <= RX_IDLE;
                        end
                    end else if (rx_cnt == rx_div - 16'd1) begin
                        if (rx_s2) begin
                            rx_push  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_ferr_set  <= 1'b1;
                            rx_wait_high <= 1'b1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // FIFO storage (no reset needed: the pointers define validity)
    always_ff @(posedge clk16) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= rx_shift;
    end

    // FIFO pointers, count and sticky flags; a set in the same cycle beats a STATUS-read clear
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
            if (rd_fire && (addr == 3'd1)) begin
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            if (rx_push && fifo_full && !pop) rx_overrun <= 1'b1;
            if (rx_ferr_set) frame_err <= 1'b1;
        end
    end

`ifdef M68K_UART_IRQ_EN
    // Registered interrupt request
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) irq_n <= 1'b1;
        else       irq_n <= !((rx_ie && rx_nonempty) || (tx_ie && !tx_full));
    end
`endif

endmodule

// File: tb/tb_m68k_uart.sv
// Self-checking bench for m68k_uart: bus reads go through a scoreboard queue,
// received bytes and transmitted bytes have their own expectation queues.
module tb_m68k_uart;
    localparam int unsigned RX_DEPTH = 8;

    logic       clk16 = 1'b0;
    logic       reset;
    logic       cs_n, as_n, lds_n, rw;
    logic [2:0] addr;
    logic [7:0] din, dout;
    logic       dout_oe, dtack_n, txd, rxd;
    logic       rxd_bench, loop_en;
`ifdef M68K_UART_IRQ_EN
    logic       irq_n;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] sb_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    assign rxd = loop_en ? txd : rxd_bench;
    always #5 clk16 = ~clk16;

    m68k_uart #(.RX_DEPTH(RX_DEPTH), .DIV_RESET(138)) dut (
        .clk16   (clk16),
        .reset   (reset),
        .cs_n    (cs_n),
        .as_n    (as_n),
        .lds_n   (lds_n),
        .rw      (rw),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .dout_oe (dout_oe),
        .dtack_n (dtack_n),
        .txd     (txd),
        .rxd     (rxd)
`ifdef M68K_UART_IRQ_EN
        ,
        .irq_n   (irq_n)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_cycle(input logic [2:0] a, input logic r, input logic [7:0] wd,
                             input logic l, output logic [7:0] d, output int lat,
                             output logic oe, output int rel, output logic oe_rel);
        @(negedge clk16);
        addr = a; rw = r; din = wd; lds_n = l; cs_n = 1'b0; as_n = 1'b0;
        lat = 0;
        do begin @(negedge clk16); lat++; end while (dtack_n !== 1'b0 && lat < 16);
        if (dtack_n !== 1'b0) check("dtack_timeout", int'(dtack_n), 0);
        d  = dout;
        oe = dout_oe;
        as_n = 1'b1; cs_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        rel = 0;
        do begin @(negedge clk16); rel++; end while (dtack_n !== 1'b1 && rel < 16);
        if (dtack_n !== 1'b1) check("release_timeout", int'(dtack_n), 1);
        oe_rel = dout_oe;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        int lat, rel;
        logic oe, oer;
        sb_q.push_back(exp);
        bus_cycle(a, 1'b1, 8'h00, 1'b0, d, lat, oe, rel, oer);
        check(tag, d, sb_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] v);
        logic [7:0] d;
        int lat, rel;
        logic oe, oer;
        bus_cycle(a, 1'b0, v, 1'b0, d, lat, oe, rel, oer);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        @(negedge clk16);
        rxd_bench = 1'b0;
        repeat (div) @(negedge clk16);
        for (int i = 0; i < 8; i++) begin
            rxd_bench = b[i];
            repeat (div) @(negedge clk16);
        end
        rxd_bench = stop;
        repeat (div) @(negedge clk16);
        rxd_bench = 1'b1;
        repeat (div) @(negedge clk16);
    endtask

    // Waits for a start bit, then samples every bit centre of one frame.
    task automatic tx_capture(input int div, output logic [7:0] b, output logic stop,
                              output int low_len, output int waitc);
        int idx;
        b = '0; stop = 1'b0; low_len = 0; waitc = 0;
        while (txd !== 1'b0 && waitc < 20000) begin
            @(negedge clk16);
            waitc++;
        end
        if (txd !== 1'b0) begin
            check("tx_start_timeout", int'(txd), 0);
            return;
        end
        for (int k = 1; k <= div * 9 + div / 2; k++) begin
            @(negedge clk16);
            if (low_len == 0 && txd === 1'b1) low_len = k;
            if (k >= div + div / 2 && (k - div - div / 2) % div == 0) begin
                idx = (k - div - div / 2) / div;
                if (idx < 8) b[idx] = txd;
                else         stop = txd;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, b0, b1, b2;
        logic       oe, oer, s0, s1, s2;
        int         lat, rel, l0, w0, l1, w1, l2, w2, lows;

        cs_n = 1'b1; as_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        addr = '0; din = '0; rxd_bench = 1'b1; loop_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk16);
        check("rst_dtack", int'(dtack_n), 1);
        check("rst_dout", int'(dout), 0);
        check("rst_oe", int'(dout_oe), 0);
        check("rst_txd", int'(txd), 1);
`ifdef M68K_UART_IRQ_EN
        check("rst_irq", int'(irq_n), 1);
`endif
        reset = 1'b0;

        // STATUS after reset with handshake timing
        sb_q.push_back(8'h02);
        bus_cycle(3'd1, 1'b1, 8'h00, 1'b0, d, lat, oe, rel, oer);
        check("st_rst", d, sb_q.pop_front());
        check("ack_lat", lat, 1);
        check("ack_oe", int'(oe), 1);
        check("rel_lat", rel, 1);
        check("rel_oe", int'(oer), 0);
        rd_chk("div_lo_rst", 3'd2, 8'h8A);
        rd_chk("div_hi_rst", 3'd3, 8'h00);
        rd_chk("data_empty", 3'd0, 8'h00);
        wr(3'd5, 8'hFF);
        rd_chk("reg5", 3'd5, 8'h00);
        wr(3'd4, 8'h03);
`ifdef M68K_UART_IRQ_EN
        rd_chk("reg4", 3'd4, 8'h03);
`else
        rd_chk("reg4", 3'd4, 8'h00);
`endif
        wr(3'd4, 8'h00);

        // TX at DIV=16, back-to-back frames, dropped write while full
        wr(3'd2, 8'h10);
        wr(3'd3, 8'h00);
        rd_chk("div_lo", 3'd2, 8'h10);
        fork
            begin
                tx_capture(16, b0, s0, l0, w0);
                check("tx_byte0", b0, tx_q.pop_front());
                check("tx_stop0", int'(s0), 1);
                check("tx_start_len", l0, 16);
                tx_capture(16, b1, s1, l1, w1);
                check("tx_byte1", b1, tx_q.pop_front());
                check("tx_stop1", int'(s1), 1);
                check("tx_gap", w1, 8);
            end
            begin
                tx_q.push_back(8'hA5);
                wr(3'd0, 8'hA5);
                rd_chk("st_tx_ready", 3'd1, 8'h02);
                tx_q.push_back(8'h5A);
                wr(3'd0, 8'h5A);
                rd_chk("st_tx_full", 3'd1, 8'h00);
                wr(3'd0, 8'hFF);
            end
        join
        lows = 0;
        repeat (300) begin
            @(negedge clk16);
            if (txd === 1'b0) lows++;
        end
        check("tx_drop", lows, 0);

        // Divisor below 4 is clamped on use but read back raw
        wr(3'd2, 8'h01);
        rd_chk("div_raw", 3'd2, 8'h01);
        fork
            begin
                tx_capture(4, b2, s2, l2, w2);
                check("clamp_byte", b2, tx_q.pop_front());
                check("clamp_len", l2, 4);
            end
            begin
                tx_q.push_back(8'h81);
                wr(3'd0, 8'h81);
            end
        join
        repeat (10) @(negedge clk16);
        wr(3'd2, 8'h10);

        // Loopback receive, upper-lane-only cycle has no side effect
        loop_en = 1'b1;
        rx_q.push_back(8'h3C);
        wr(3'd0, 8'h3C);
        repeat (220) @(negedge clk16);
        rd_chk("lb_st", 3'd1, 8'h03);
        bus_cycle(3'd0, 1'b1, 8'h00, 1'b1, d, lat, oe, rel, oer);
        check("uds_dout", d, 0);
        check("uds_lat", lat, 1);
        rd_chk("lb_data", 3'd0, rx_q.pop_front());
        rd_chk("lb_st_after", 3'd1, 8'h02);
        loop_en = 1'b0;

        // Framing error, then a short glitch, then a good frame
        send_rx(8'h55, 1'b0, 16);
        repeat (10) @(negedge clk16);
        rd_chk("ferr_st", 3'd1, 8'h0A);
        rd_chk("ferr_clr", 3'd1, 8'h02);
        @(negedge clk16);
        rxd_bench = 1'b0;
        repeat (3) @(negedge clk16);
        rxd_bench = 1'b1;
        repeat (50) @(negedge clk16);
        rd_chk("glitch_st", 3'd1, 8'h02);
        rx_q.push_back(8'h96);
        send_rx(8'h96, 1'b1, 16);
        rd_chk("rx_ok_st", 3'd1, 8'h03);
        rd_chk("rx_ok_data", 3'd0, rx_q.pop_front());

`ifdef M68K_UART_IRQ_EN
        wr(3'd4, 8'h01);
        rx_q.push_back(8'h77);
        send_rx(8'h77, 1'b1, 16);
        check("irq_rx", int'(irq_n), 0);
        rd_chk("irq_data", 3'd0, rx_q.pop_front());
        check("irq_clr", int'(irq_n), 1);
        wr(3'd4, 8'h02);
        repeat (2) @(negedge clk16);
        check("irq_tx", int'(irq_n), 0);
        wr(3'd4, 8'h00);
        repeat (2) @(negedge clk16);
        check("irq_off", int'(irq_n), 1);
`endif

        // Overrun: hold TX busy on a long divisor so the holding register stays full
        wr(3'd2, 8'hB8);
        wr(3'd3, 8'h0B);
        wr(3'd0, 8'h11);
        wr(3'd0, 8'h22);
        wr(3'd2, 8'h10);
        wr(3'd3, 8'h00);
        for (int i = 0; i <= RX_DEPTH; i++) begin
            b0 = 8'h40 + 8'(i);
            if (i < RX_DEPTH) rx_q.push_back(b0);
            send_rx(b0, 1'b1, 16);
        end
        rd_chk("ovr_st", 3'd1, 8'h05);
        for (int i = 0; i < RX_DEPTH; i++) rd_chk("ovr_data", 3'd0, rx_q.pop_front());
        rd_chk("ovr_clr", 3'd1, 8'h00);

        // Reset while acknowledging
        @(negedge clk16);
        addr = 3'd1; rw = 1'b1; lds_n = 1'b0; cs_n = 1'b0; as_n = 1'b0;
        @(negedge clk16);
        check("ack_pre_rst", int'(dtack_n), 0);
        reset = 1'b1;
        #1;
        check("rst_in_ack", int'(dtack_n), 1);
        check("rst_in_ack_oe", int'(dout_oe), 0);
        check("rst_txd_mid", int'(txd), 1);
        as_n = 1'b1; cs_n = 1'b1; lds_n = 1'b1;
        @(negedge clk16);
        reset = 1'b0;
        rd_chk("div_after_rst", 3'd2, 8'h8A);
        rd_chk("st_after_rst", 3'd1, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/m68k_uart.md
Name: m68k_uart

Overview:
- Byte-wide UART peripheral on the 68k bus, selected by the address decoder's DEV_OTHER chip select (first peripheral in the 0x104000+ region).
- Decodes its own register offsets and generates its own dtack_n, so the decoder only supplies the chip select.
- Provides 8N1 TX/RX with a programmable divisor and a small RX FIFO.
- Sits directly downstream of the address decoder, on clk16.

Parameters:
- RX_DEPTH, 8: RX FIFO entries; must be a power of two, >= 2.
- DIV_RESET, 138: baud divisor after reset. Bit period = DIV_RESET clk16 cycles (16 MHz / 138 ≈ 115200 baud).

Ports:
- clk16  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs_n  in  1  chip select from decoder, active low
- as_n  in  1  68k address strobe
- lds_n  in  1  lower data strobe; registers live on D7..D0
- rw  in  1  1 = read, 0 = write
- addr  in  3  A3..A1, register select
- din  in  8  CPU write data D7..D0
- dout  out  8  read data, registered
- dout_oe  out  1  1 while read data must be driven onto the bus
- dtack_n  out  1  data acknowledge, active low
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous

Behaviour:
- Reset (async): dtack_n=1, dout=0, dout_oe=0, txd=1, FIFO empty, sticky flags=0, divisor=DIV_RESET, TX and RX in IDLE.
- Register map (addr):
  - 0 DATA
    - Read pops the RX FIFO; reading when empty returns 0x00 and pops nothing.
    - Write loads the TX holding register only if it is empty; otherwise the write is dropped.
  - 1 STATUS, read-only: bit0 rx_nonempty, bit1 tx_ready (holding empty), bit2 rx_overrun, bit3 frame_err, bits7..4 = 0.
    - Reading STATUS clears bit2 and bit3 after returning their current values.
  - 2 DIV_LO, 3 DIV_HI: 16-bit divisor, read/write. Values < 4 are clamped to 4 on use.
  - 5..7: reads 0x00, writes ignored.
- Bus FSM with states IDLE, ACK:
  - IDLE -> ACK on the first clk16 edge with cs_n=0, as_n=0, lds_n=0.
  - The register side effect (pop/write/flag clear) executes exactly once, on that transition edge. Read data is latched into dout on the same edge.
  - In ACK: dtack_n=0 and dout_oe=rw. Latency is 1 clk from the strobe to dtack_n low.
  - ACK -> IDLE when as_n=1. At that point dtack_n=1 and dout_oe=0.
  - uds_n-only cycles: the block acknowledges, dout=0x00, and there is no side effect.
  - Reset during ACK: dtack_n returns to 1 immediately.
- TX (IDLE, START, DATA, STOP):
  - A non-empty holding register moves into the shifter and the holding register frees (tx_ready=1) on the same cycle.
  - The divisor is latched at frame start; each bit lasts divisor cycles, sent LSB first.
  - After STOP, TX returns to IDLE and starts the next byte immediately if the holding register is full. Back-to-back frames have no idle gap.
- RX (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchroniser. A falling edge in IDLE starts the frame and latches the divisor.
  - START: at divisor/2 (integer division) the line is re-sampled. If high it is a false start: return to IDLE and discard.
  - DATA: 8 samples, each one divisor apart, LSB first.
  - STOP: a sample of 1 pushes the byte. A sample of 0 sets frame_err, discards the byte, and waits for rxd=1 before returning to IDLE.
- FIFO:
  - Push when full: byte dropped, rx_overrun set.
  - Simultaneous pop and push: both occur, count unchanged. Full plus pop plus push is not an overrun.
  - Pointers wrap modulo RX_DEPTH; the count is log2(RX_DEPTH)+1 bits wide.

Optional Feature:
- M68K_UART_IRQ_EN defined:
  - Adds port irq_n (out, 1, active low, reset 1) and register 4 CTRL: bit0 rx_ie, bit1 tx_ie, read/write, reset 0.
  - irq_n = ~((rx_ie & rx_nonempty) | (tx_ie & tx_ready)), registered (1 clk latency).
- Not defined: no irq_n port; register 4 reads 0x00 and ignores writes.

Test Plan:
- Read STATUS after reset (cs_n=0, as_n=0, lds_n=0, rw=1) -> dtack_n low 1 clk later, dout=0x02. Drop as_n -> dtack_n=1 and dout_oe=0 next edge.
- DIV=16, write DATA 0xA5 -> txd low for 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, stop high. tx_ready=1 from the cycle after the write.
- Loop txd->rxd, DIV=16, send 0x3C -> STATUS bit0=1, DATA read returns 0x3C, STATUS bit0 then 0.
- Receive RX_DEPTH+1 bytes without reading -> STATUS=0x05. First RX_DEPTH bytes read back in order; the next STATUS read returns bit2=0.
- rxd frame with stop bit=0 -> FIFO unchanged, STATUS bit3=1. A 3-clk low glitch with DIV=16 -> no push, no flags.
- With M68K_UART_IRQ_EN: CTRL=0x01, receive a byte -> irq_n=0. Read DATA -> irq_n=1 one clk after the pop.
